hazard_sequencer: RTL and testbench
===================================

// Module: hazard_sequencer
// PURPOSE
//  Sequences the 5-stage pipeline behind SistemaControl: drives PC/nPC/IF-ID load enables,
//  the control-signal mux select S (1 = NOP into ID/EX), branch target select and operand
//  forwarding selects. Holds the pipe in a post-reset warm-up, inserts load-use bubbles and
//  resolves ID-stage branches (BGTZ/JAL) with one architectural delay slot.
// PARAMETERS
//  WARMUP_CYCLES    4   cycles after reset release with PC held and S=1 (pipe drained to NOPs)
//  LOAD_USE_BUBBLES 1   bubbles per load-use hazard (1 = load data forwardable from MEM; max 3)
//  CNT_W            16  width of stall_count
// PORTS
//  clk          in   1      pipeline clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  id_rs/id_rt  in   5 ea   source regs of instruction in ID
//  id_use_rs/rt in   1 ea   ID instruction actually reads rs / rt
//  ex_rd        in   5      dest reg in EX;  ex_rf_en in 1; ex_load in 1 (LBU etc.)
//  mem_rd       in   5      dest reg in MEM; mem_rf_en in 1
//  wb_rd        in   5      dest reg in WB;  wb_rf_en in 1
//  id_br_taken  in   1      branch/jump in ID resolved taken this cycle
//  pc_ld        out  1      PC register load enable
//  npc_ld       out  1      nPC register load enable
//  ifid_ld      out  1      IF/ID register load enable
//  cu_mux_sel   out  1      S: 1 = zero control signals into ID/EX
//  tgt_sel      out  1      1 = nPC loads branch target, 0 = nPC+4
//  fwd_a/fwd_b  out  2 ea   00 RF, 01 EX, 10 MEM, 11 WB
//  stall_count  out  CNT_W  saturating count of bubble cycles since reset
// BEHAVIOUR
//  - Reset low (any time, async): state=WARMUP, warm counter=0, stall_count=0; outputs
//    pc_ld=npc_ld=ifid_ld=0, cu_mux_sel=1, tgt_sel=0, fwd_*=00. Reset mid-stall aborts the stall.
//  - FSM WARMUP -> RUN after WARMUP_CYCLES rising edges with reset high; outputs as in reset.
//  - RUN: hazard = ex_load & ex_rf_en & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) |
//    (id_use_rt & id_rt==ex_rd)). Combinational, same cycle.
//    hazard=0: pc_ld=npc_ld=ifid_ld=1, cu_mux_sel=0, tgt_sel=id_br_taken.
//    hazard=1: pc_ld=npc_ld=ifid_ld=0, cu_mux_sel=1, tgt_sel=0 (bubble 1); if
//    LOAD_USE_BUBBLES>1 go STALL with bub counter=LOAD_USE_BUBBLES-1, else stay RUN.
//  - STALL: same outputs as hazard=1 regardless of inputs; decrement bub counter each edge,
//    -> RUN when it reaches 0. Hazard is re-evaluated fresh in RUN.
//  - Branch + hazard same cycle: stall wins, id_br_taken ignored; branch stays in ID and is
//    re-evaluated when the stall ends. Delay slot never squashed (no flush output).
//  - Forwarding (valid in all states, forced 00 in WARMUP): per operand, priority EX>MEM>WB,
//    source qualifies iff its rf_en=1, rd!=0, rd==src; EX source excluded if ex_load=1. Reg 0
//    always 00.
//  - stall_count += 1 on each edge where cu_mux_sel=1 in RUN/STALL; saturates at all-ones.
// STRUCTURE
//  - pipeline_pkg: state enum {WARMUP, RUN, STALL}, FWD_RF/EX/MEM/WB codes, REG_ZERO.
//  - Sub-module forwarding_unit (combinational, instanced twice for A and B); FSM, counters
//    and enable logic in this module.
// TESTING
//  1. reset low 3 cycles, release: 4 cycles pc_ld=0, S=1; 5th cycle pc_ld=1, S=0.
//  2. EX: LBU r5 (ex_load=1); ID: ADDIU reads rs=5 -> one cycle pc_ld=ifid_ld=0, S=1;
//     next cycle pc_ld=1, fwd_a=10; stall_count=1.
//  3. EX: SUBU r3, MEM: r3, WB: r3; ID reads rs=rt=3 -> fwd_a=fwd_b=01; EX writing r0 -> 00.
//  4. BGTZ taken in ID, no hazard -> tgt_sel=1 one cycle, all enables 1 (delay slot fetched).
//  5. Load-use + id_br_taken=1 same cycle -> tgt_sel=0, S=1; next cycle tgt_sel=1.
//  6. LOAD_USE_BUBBLES=2, hazard then reset low during STALL -> outputs reset values
//     immediately; stall_count=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and codes for the pipeline hazard sequencer
package pipeline_pkg;
   typedef enum logic [1:0] {WARMUP, RUN, STALL} state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - operand forwarding select for one ID-stage source register
module forwarding_unit
   import pipeline_pkg::*;
(
   input  logic [4:0] src,
   input  logic [4:0] ex_rd,
   input  logic       ex_rf_en,
   input  logic       ex_load,
   input  logic [4:0] mem_rd,
   input  logic       mem_rf_en,
   input  logic [4:0] wb_rd,
   input  logic       wb_rf_en,
   output logic [1:0] fwd
);

   // A load in EX has no data yet, so it never wins; the hazard logic stalls instead.
   always_comb begin
      fwd = FWD_RF;
      if (src != REG_ZERO) begin
         if (ex_rf_en && !ex_load && (ex_rd == src))
            fwd = FWD_EX;
         else if (mem_rf_en && (mem_rd == src))
            fwd = FWD_MEM;
         else if (wb_rf_en && (wb_rd == src))
            fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - warm-up, load-use stall, branch select and forwarding control
module hazard_sequencer
   import pipeline_pkg::*;
#(
   parameter int WARMUP_CYCLES    = 4,
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int CNT_W            = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [4:0]       ex_rd,
   input  logic             ex_rf_en,
   input  logic             ex_load,
   input  logic [4:0]       mem_rd,
   input  logic             mem_rf_en,
   input  logic [4:0]       wb_rd,
   input  logic             wb_rf_en,
   input  logic             id_br_taken,
   output logic             pc_ld,
   output logic             npc_ld,
   output logic             ifid_ld,
   output logic             cu_mux_sel,
   output logic             tgt_sel,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_count
);

   localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES + 1) : 1;

   state_t            state;
   state_t            state_next;
   logic [WARM_W-1:0] warm_cnt;
   logic [1:0]        bub_cnt;
   logic              hazard;
   logic [1:0]        fwd_a_raw;
   logic [1:0]        fwd_b_raw;

   assign hazard = ex_load && ex_rf_en && (ex_rd != REG_ZERO) &&
                   ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= WARMUP;
         warm_cnt    <= '0;
         bub_cnt     <= '0;
         stall_count <= '0;
      end else begin
         state <= state_next;
         if (state == WARMUP)
            warm_cnt <= warm_cnt + 1'b1;
         if (state == RUN && state_next == STALL)
            bub_cnt <= 2'(LOAD_USE_BUBBLES - 1);
         else if (state == STALL)
            bub_cnt <= bub_cnt - 1'b1;
         if (state != WARMUP && cu_mux_sel && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end

   // Outputs default to the bubble/held values shared by WARMUP, STALL and a RUN hazard.
   always_comb begin
      state_next = state;
      pc_ld      = 1'b0;
      npc_ld     = 1'b0;
      ifid_ld    = 1'b0;
      cu_mux_sel = 1'b1;
      tgt_sel    = 1'b0;
      case (state)
         WARMUP: begin
            if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1))
               state_next = RUN;
         end
         RUN: begin
            if (!hazard) begin
               pc_ld      = 1'b1;
               npc_ld     = 1'b1;
               ifid_ld    = 1'b1;
               cu_mux_sel = 1'b0;
               tgt_sel    = id_br_taken;
            end else if (LOAD_USE_BUBBLES > 1) begin
               state_next = STALL;
            end
         end
         STALL: begin
            if (bub_cnt == 2'd1)
               state_next = RUN;
         end
         default: state_next = WARMUP;
      endcase
   end

   forwarding_unit u_fwd_a (
      .src       (id_rs),
      .ex_rd     (ex_rd),
      .ex_rf_en  (ex_rf_en),
      .ex_load   (ex_load),
      .mem_rd    (mem_rd),
      .mem_rf_en (mem_rf_en),
      .wb_rd     (wb_rd),
      .wb_rf_en  (wb_rf_en),
      .fwd       (fwd_a_raw)
   );

   forwarding_unit u_fwd_b (
      .src       (id_rt),
      .ex_rd     (ex_rd),
      .ex_rf_en  (ex_rf_en),
      .ex_load   (ex_load),
      .mem_rd    (mem_rd),
      .mem_rf_en (mem_rf_en),
      .wb_rd     (wb_rd),
      .wb_rf_en  (wb_rf_en),
      .fwd       (fwd_b_raw)
   );

   assign fwd_a = (state == WARMUP) ? FWD_RF : fwd_a_raw;
   assign fwd_b = (state == WARMUP) ? FWD_RF : fwd_b_raw;

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - scoreboard bench for hazard_sequencer (1 and 2 bubble builds)
module tb_hazard_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        reset2;
   logic [4:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
   logic        id_use_rs, id_use_rt, ex_rf_en, ex_load, mem_rf_en, wb_rf_en, id_br_taken;

   logic        pc_ld, npc_ld, ifid_ld, cu_mux_sel, tgt_sel;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_count;

   logic        d2_pc_ld, d2_npc_ld, d2_ifid_ld, d2_cu_mux_sel, d2_tgt_sel;
   logic [1:0]  d2_fwd_a, d2_fwd_b;
   logic [15:0] d2_stall_count;

   always #5 clk = ~clk;

   hazard_sequencer dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_load(ex_load),
      .mem_rd(mem_rd), .mem_rf_en(mem_rf_en), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
      .id_br_taken(id_br_taken),
      .pc_ld(pc_ld), .npc_ld(npc_ld), .ifid_ld(ifid_ld), .cu_mux_sel(cu_mux_sel),
      .tgt_sel(tgt_sel), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
   );

   hazard_sequencer #(.LOAD_USE_BUBBLES(2)) dut2 (
      .clk(clk), .reset(reset2),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_load(ex_load),
      .mem_rd(mem_rd), .mem_rf_en(mem_rf_en), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
      .id_br_taken(id_br_taken),
      .pc_ld(d2_pc_ld), .npc_ld(d2_npc_ld), .ifid_ld(d2_ifid_ld), .cu_mux_sel(d2_cu_mux_sel),
      .tgt_sel(d2_tgt_sel), .fwd_a(d2_fwd_a), .fwd_b(d2_fwd_b), .stall_count(d2_stall_count)
   );

   typedef struct {
      logic        which;
      logic        pc;
      logic        s;
      logic        tgt;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [15:0] sc;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got === want)
         passed++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   task automatic idle();
      id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      ex_rd = 5'd0; ex_rf_en = 1'b0; ex_load = 1'b0;
      mem_rd = 5'd0; mem_rf_en = 1'b0; wb_rd = 5'd0; wb_rf_en = 1'b0;
      id_br_taken = 1'b0;
   endtask

   // Push the expectation for the current input set, then compare on the falling edge.
   task automatic expect_cycle(input string tag, input logic which, input logic pc,
                               input logic s, input logic tgt, input logic [1:0] fa,
                               input logic [1:0] fb, input logic [15:0] sc);
      exp_t e;
      e.which = which; e.pc = pc; e.s = s; e.tgt = tgt; e.fa = fa; e.fb = fb; e.sc = sc;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      if (!e.which) begin
         check({tag, ".pc_ld"},   32'(pc_ld),       32'(e.pc));
         check({tag, ".npc_ld"},  32'(npc_ld),      32'(e.pc));
         check({tag, ".ifid_ld"}, 32'(ifid_ld),     32'(e.pc));
         check({tag, ".s"},       32'(cu_mux_sel),  32'(e.s));
         check({tag, ".tgt"},     32'(tgt_sel),     32'(e.tgt));
         check({tag, ".fwd_a"},   32'(fwd_a),       32'(e.fa));
         check({tag, ".fwd_b"},   32'(fwd_b),       32'(e.fb));
         check({tag, ".stalls"},  32'(stall_count), 32'(e.sc));
      end else begin
         check({tag, ".pc_ld"},   32'(d2_pc_ld),       32'(e.pc));
         check({tag, ".npc_ld"},  32'(d2_npc_ld),      32'(e.pc));
         check({tag, ".ifid_ld"}, 32'(d2_ifid_ld),     32'(e.pc));
         check({tag, ".s"},       32'(d2_cu_mux_sel),  32'(e.s));
         check({tag, ".tgt"},     32'(d2_tgt_sel),     32'(e.tgt));
         check({tag, ".fwd_a"},   32'(d2_fwd_a),       32'(e.fa));
         check({tag, ".fwd_b"},   32'(d2_fwd_b),       32'(e.fb));
         check({tag, ".stalls"},  32'(d2_stall_count), 32'(e.sc));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset  = 1'b0;
      reset2 = 1'b0;
      idle();

      repeat (3) expect_cycle("reset", 0, 0, 1, 0, 2'b00, 2'b00, 16'd0);

      // Warm-up with inputs that would otherwise forward from EX.
      reset = 1'b1;
      ex_rd = 5'd3; ex_rf_en = 1'b1; id_rs = 5'd3; id_rt = 5'd3;
      for (int i = 0; i < 4; i++) expect_cycle("warmup", 0, 0, 1, 0, 2'b00, 2'b00, 16'd0);
      idle();
      expect_cycle("first_run", 0, 1, 0, 0, 2'b00, 2'b00, 16'd0);

      idle(); ex_rd = 5'd5; ex_load = 1'b1; ex_rf_en = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1;
      expect_cycle("load_use", 0, 0, 1, 0, 2'b00, 2'b00, 16'd0);
      idle(); mem_rd = 5'd5; mem_rf_en = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1;
      expect_cycle("load_fwd", 0, 1, 0, 0, 2'b10, 2'b00, 16'd1);

      idle(); ex_rd = 5'd3; ex_rf_en = 1'b1; mem_rd = 5'd3; mem_rf_en = 1'b1;
      wb_rd = 5'd3; wb_rf_en = 1'b1; id_rs = 5'd3; id_rt = 5'd3; id_use_rs = 1'b1; id_use_rt = 1'b1;
      expect_cycle("fwd_ex_prio", 0, 1, 0, 0, 2'b01, 2'b01, 16'd1);
      ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
      expect_cycle("fwd_r0", 0, 1, 0, 0, 2'b00, 2'b00, 16'd1);
      mem_rd = 5'd3; wb_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
      expect_cycle("fwd_mem_wb", 0, 1, 0, 0, 2'b10, 2'b11, 16'd1);
      idle(); mem_rd = 5'd3; wb_rd = 5'd3; wb_rf_en = 1'b1; id_rs = 5'd3; id_rt = 5'd9;
      expect_cycle("fwd_mem_off", 0, 1, 0, 0, 2'b11, 2'b00, 16'd1);
      idle(); ex_rd = 5'd4; ex_load = 1'b1; ex_rf_en = 1'b1; mem_rd = 5'd4; mem_rf_en = 1'b1; id_rs = 5'd4;
      expect_cycle("load_unused", 0, 1, 0, 0, 2'b10, 2'b00, 16'd1);
      idle(); ex_load = 1'b1; ex_rf_en = 1'b1; id_use_rs = 1'b1;
      expect_cycle("load_r0", 0, 1, 0, 0, 2'b00, 2'b00, 16'd1);

      idle(); id_br_taken = 1'b1;
      expect_cycle("branch", 0, 1, 0, 1, 2'b00, 2'b00, 16'd1);
      idle();
      expect_cycle("delay_slot", 0, 1, 0, 0, 2'b00, 2'b00, 16'd1);

      idle(); ex_rd = 5'd6; ex_load = 1'b1; ex_rf_en = 1'b1; id_rt = 5'd6; id_use_rt = 1'b1; id_br_taken = 1'b1;
      expect_cycle("br_stall", 0, 0, 1, 0, 2'b00, 2'b00, 16'd1);
      idle(); mem_rd = 5'd6; mem_rf_en = 1'b1; id_rt = 5'd6; id_use_rt = 1'b1; id_br_taken = 1'b1;
      expect_cycle("br_after", 0, 1, 0, 1, 2'b00, 2'b10, 16'd2);
      idle();
      expect_cycle("idle_run", 0, 1, 0, 0, 2'b00, 2'b00, 16'd2);

      // Two-bubble build: stall, then reset in the middle of a stall.
      reset2 = 1'b1;
      for (int i = 0; i < 4; i++) expect_cycle("d2_warmup", 1, 0, 1, 0, 2'b00, 2'b00, 16'd0);
      expect_cycle("d2_run", 1, 1, 0, 0, 2'b00, 2'b00, 16'd0);
      idle(); ex_rd = 5'd5; ex_load = 1'b1; ex_rf_en = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1;
      expect_cycle("d2_bubble1", 1, 0, 1, 0, 2'b00, 2'b00, 16'd0);
      idle(); id_br_taken = 1'b1;
      expect_cycle("d2_bubble2", 1, 0, 1, 0, 2'b00, 2'b00, 16'd1);
      idle();
      expect_cycle("d2_resume", 1, 1, 0, 0, 2'b00, 2'b00, 16'd2);
      ex_rd = 5'd5; ex_load = 1'b1; ex_rf_en = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1;
      expect_cycle("d2_hazard", 1, 0, 1, 0, 2'b00, 2'b00, 16'd2);
      reset2 = 1'b0;
      idle(); ex_rd = 5'd4; ex_rf_en = 1'b1; id_rs = 5'd4;
      expect_cycle("d2_reset", 1, 0, 1, 0, 2'b00, 2'b00, 16'd0);
      reset2 = 1'b1;
      idle();
      for (int i = 0; i < 4; i++) expect_cycle("d2_rewarm", 1, 0, 1, 0, 2'b00, 2'b00, 16'd0);
      expect_cycle("d2_rerun", 1, 1, 0, 0, 2'b00, 2'b00, 16'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
